// File: rtl/face_match_driver_pkg.sv
// ============================================================================
// face_match_driver_pkg : shared FSM encodings, status codes, FP32 constants
// Rev 1.0
// ============================================================================
`default_nettype none

package face_match_driver_pkg;

  typedef enum logic [1:0] {
    S_LOAD = 2'b00,
    S_FIRE = 2'b01,
    S_WAIT = 2'b10,
    S_RESP = 2'b11
  } state_e;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_ZNORM = 2'b01;
  localparam logic [1:0] ST_TMO   = 2'b10;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_MAG_W = FP_EXP_W + FP_MAN_W;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;

  function automatic logic fp32_is_nan(input logic [31:0] v);
    return (v[FP_MAG_W-1:FP_MAN_W] == '1) && (v[FP_MAN_W-1:0] != '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/face_match_driver_fp32_ge.sv
// ============================================================================
// fp32_ge : combinational FP32 a >= b (sign-magnitude order, +0 == -0, NaN -> 0)
// Rev 1.0
// ============================================================================
`default_nettype none

module fp32_ge
  import face_match_driver_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        ge_o
);

  logic [FP_MAG_W-1:0] a_mag;
  logic [FP_MAG_W-1:0] b_mag;
  logic                a_neg;
  logic                b_neg;

  assign a_mag = a_i[FP_MAG_W-1:0];
  assign b_mag = b_i[FP_MAG_W-1:0];
  assign a_neg = a_i[31];
  assign b_neg = b_i[31];

  always_comb begin
    ge_o = 1'b0;
    if (fp32_is_nan(a_i) || fp32_is_nan(b_i)) begin
      ge_o = 1'b0;
    end else if ((a_mag == '0) && (b_mag == '0)) begin
      ge_o = 1'b1;
    end else if (!a_neg && b_neg) begin
      ge_o = 1'b1;
    end else if (a_neg && !b_neg) begin
      ge_o = 1'b0;
    end else if (!a_neg) begin
      ge_o = (a_mag >= b_mag);
    end else begin
      // both negative: larger magnitude is the smaller value
      ge_o = (a_mag <= b_mag);
    end
  end

endmodule

`default_nettype wire

// File: rtl/face_match_driver.sv
// ============================================================================
// face_match_driver : streams two FP32 embeddings into the cosine IP, fires it,
//                     waits for done/error/timeout and returns a scored response.
// Rev 1.0
// ============================================================================
`default_nettype none

module face_match_driver
  import face_match_driver_pkg::*;
#(
  parameter int D_Len       = 32,
  parameter int Ele_Num     = 128,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [D_Len-1:0]         in_data_i,
  input  logic [D_Len-1:0]         thresh_i,
  output logic [D_Len*Ele_Num-1:0] ip_vct1_o,
  output logic [D_Len*Ele_Num-1:0] ip_vct2_o,
  output logic                     ip_start_o,
  input  logic [D_Len-1:0]         ip_result_i,
  input  logic                     ip_done_i,
  input  logic                     ip_error_i,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic [D_Len-1:0]         resp_score_o,
  output logic                     resp_match_o,
  output logic [1:0]               resp_status_o,
  output logic                     busy_o
);

  localparam int CNT_W = $clog2(2*Ele_Num);
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(2*Ele_Num-1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYC-1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [D_Len-1:0]   thresh_q, thresh_d;
  logic [D_Len-1:0]   score_q, score_d;
  logic               match_q, match_d;
  logic [1:0]         status_q, status_d;
  logic               load_accept;
  logic               result_ge;

  assign load_accept = in_valid_i && (state_q == S_LOAD);

  fp32_ge u_ge (
    .a_i  (ip_result_i),
    .b_i  (thresh_q),
    .ge_o (result_ge)
  );

  // Each element owns its register; only the slot addressed by cnt_q is written.
  for (genvar i = 0; i < Ele_Num; i++) begin : g_elem
    logic [D_Len-1:0] e1_q;
    logic [D_Len-1:0] e2_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        e1_q <= '0;
        e2_q <= '0;
      end else if (load_accept) begin
        if (cnt_q == CNT_W'(i))         e1_q <= in_data_i;
        if (cnt_q == CNT_W'(i+Ele_Num)) e2_q <= in_data_i;
      end
    end

    assign ip_vct1_o[i*D_Len +: D_Len] = e1_q;
    assign ip_vct2_o[i*D_Len +: D_Len] = e2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_LOAD;
      cnt_q    <= '0;
      timer_q  <= '0;
      thresh_q <= '0;
      score_q  <= '0;
      match_q  <= 1'b0;
      status_q <= ST_OK;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      thresh_q <= thresh_d;
      score_q  <= score_d;
      match_q  <= match_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    thresh_d = thresh_q;
    score_d  = score_q;
    match_d  = match_q;
    status_d = status_q;

    unique case (state_q)
      S_LOAD: begin
        if (load_accept) begin
          if (cnt_q == '0) thresh_d = thresh_i;
          if (cnt_q == LAST_WORD) begin
            cnt_d   = '0;
            state_d = S_FIRE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_FIRE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        // error outranks a same-cycle done; timeout only when the IP is silent
        if (ip_error_i) begin
          status_d = ST_ZNORM;
          score_d  = '0;
          match_d  = 1'b0;
          state_d  = S_RESP;
        end else if (ip_done_i) begin
          status_d = ST_OK;
          score_d  = ip_result_i;
          match_d  = result_ge;
          state_d  = S_RESP;
        end else if (timer_q == TMR_LAST) begin
          status_d = ST_TMO;
          score_d  = '0;
          match_d  = 1'b0;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready_i) begin
          state_d  = S_LOAD;
          score_d  = '0;
          match_d  = 1'b0;
          status_d = ST_OK;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    in_ready_o    = (state_q == S_LOAD);
    ip_start_o    = (state_q == S_FIRE);
    resp_valid_o  = (state_q == S_RESP);
    busy_o        = (state_q != S_LOAD);
    resp_score_o  = score_q;
    resp_match_o  = match_q;
    resp_status_o = status_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_face_match_driver.sv
// ============================================================================
// tb_face_match_driver : table-driven job bench with a behavioural cosine-IP model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_face_match_driver;

  localparam int DL  = 32;
  localparam int EN  = 128;
  localparam int TMO = 64;
  localparam int M_DONE   = 0;
  localparam int M_ERR    = 1;
  localparam int M_SILENT = 2;
  localparam int NJOBS    = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DL-1:0]    in_data = '0;
  logic [DL-1:0]    thresh = '0;
  logic [DL*EN-1:0] ip_vct1, ip_vct2;
  logic             ip_start;
  logic [DL-1:0]    ip_result = '0;
  logic             ip_done = 1'b0;
  logic             ip_error = 1'b0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [DL-1:0]    resp_score;
  logic             resp_match;
  logic [1:0]       resp_status;
  logic             busy;

  face_match_driver #(.D_Len(DL), .Ele_Num(EN), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .thresh_i(thresh),
    .ip_vct1_o(ip_vct1), .ip_vct2_o(ip_vct2), .ip_start_o(ip_start),
    .ip_result_i(ip_result), .ip_done_i(ip_done), .ip_error_i(ip_error),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_score_o(resp_score),
    .resp_match_o(resp_match), .resp_status_o(resp_status), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural IP: counts starts, answers after mdl_lat cycles per mdl_mode
  int          mdl_mode = M_DONE;
  int          mdl_lat = 1;
  logic [31:0] mdl_res = '0;
  int          starts = 0;
  int          start_cyc = -1;
  int          pulse_cyc = -1;
  bit          late_req = 1'b0;

  initial begin
    bit pending;
    int lat_cnt;
    pending = 1'b0;
    lat_cnt = 0;
    forever begin
      @(negedge clk);
      ip_done  = 1'b0;
      ip_error = 1'b0;
      if (late_req) begin
        ip_done   = 1'b1;
        ip_result = 32'h3F80_0000;
        late_req  = 1'b0;
      end
      if (pending) begin
        if (lat_cnt <= 0) begin
          pending   = 1'b0;
          pulse_cyc = cyc;
          ip_done   = 1'b1;
          ip_error  = (mdl_mode == M_ERR);
          ip_result = mdl_res;
        end else begin
          lat_cnt--;
        end
      end
      if (ip_start) begin
        starts++;
        start_cyc = cyc;
        if (mdl_mode != M_SILENT) begin
          pending = 1'b1;
          lat_cnt = mdl_lat - 1;
        end
      end
    end
  end

  typedef struct {
    int          pat;
    int          mode;
    int          lat;
    logic [31:0] thr;
    logic [31:0] res;
    bit          gaps;
    int          rr_wait;
    logic [31:0] e_score;
    bit          e_match;
    logic [1:0]  e_status;
  } job_t;

  job_t jobs [NJOBS];

  function automatic logic [31:0] elem(input int pat, input int v, input int i);
    case (pat)
      0:       return 32'h3F80_0000;
      1:       return ((v == 0 && i == 0) || (v == 1 && i == 1)) ? 32'h3F80_0000 : 32'h0;
      default: return 32'hA500_0000 | (32'(v) << 16) | 32'(i);
    endcase
  endfunction

  task automatic load_words(input int pat, input logic [31:0] thr, input bit gaps,
                            input int nwords, output int last_cyc, output int miss);
    int g;
    miss = 0;
    last_cyc = -1;
    for (int w = 0; w < nwords; w++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        in_valid = 1'b0;
        repeat (g) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = elem(pat, w / EN, w % EN);
      thresh   = (w == 0) ? thr : 32'hDEAD_BEEF;
      if (!in_ready) miss++;
      last_cyc = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_job(input int j);
    job_t jb;
    int last_cyc, miss, base, r_cyc, mism, unstable;
    bit seen;
    logic [31:0] s_score;
    logic        s_match;
    logic [1:0]  s_status;
    logic [DL*EN-1:0] s_v1, s_v2;
    jb = jobs[j];
    mdl_mode = jb.mode;
    mdl_lat  = jb.lat;
    mdl_res  = jb.res;
    base     = starts;
    load_words(jb.pat, jb.thr, jb.gaps, 2*EN, last_cyc, miss);
    check($sformatf("job%0d load_ready", j), 64'(miss), 0);
    check($sformatf("job%0d fire_in_ready", j), 64'(in_ready), 0);
    check($sformatf("job%0d fire_start", j), 64'(ip_start), 1);
    seen = 1'b0;
    r_cyc = -1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1'b1;
        r_cyc = cyc;
        break;
      end
    end
    check($sformatf("job%0d resp_seen", j), 64'(seen), 1);
    check($sformatf("job%0d status", j), 64'(resp_status), 64'(jb.e_status));
    check($sformatf("job%0d score", j), 64'(resp_score), 64'(jb.e_score));
    check($sformatf("job%0d match", j), 64'(resp_match), 64'(jb.e_match));
    check($sformatf("job%0d start_count", j), 64'(starts - base), 1);
    check($sformatf("job%0d start_latency", j), 64'(start_cyc - last_cyc), 1);
    if (jb.mode == M_SILENT)
      check($sformatf("job%0d timeout_latency", j), 64'(r_cyc - start_cyc - 1), 64'(TMO));
    else
      check($sformatf("job%0d resp_latency", j), 64'(r_cyc - pulse_cyc), 1);
    mism = 0;
    for (int i = 0; i < EN; i++) begin
      if (ip_vct1[i*DL +: DL] !== elem(jb.pat, 0, i)) mism++;
      if (ip_vct2[i*DL +: DL] !== elem(jb.pat, 1, i)) mism++;
    end
    check($sformatf("job%0d packing", j), 64'(mism), 0);
    check($sformatf("job%0d busy", j), 64'(busy), 1);
    if (jb.rr_wait > 0) begin
      s_score = resp_score; s_match = resp_match; s_status = resp_status;
      s_v1 = ip_vct1; s_v2 = ip_vct2;
      unstable = 0;
      repeat (jb.rr_wait) begin
        @(negedge clk);
        if (resp_score !== s_score || resp_match !== s_match || resp_status !== s_status ||
            ip_vct1 !== s_v1 || ip_vct2 !== s_v2 || in_ready !== 1'b0 || resp_valid !== 1'b1)
          unstable++;
      end
      check($sformatf("job%0d hold_stable", j), 64'(unstable), 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check($sformatf("job%0d post_in_ready", j), 64'(in_ready), 1);
    check($sformatf("job%0d post_resp_valid", j), 64'(resp_valid), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_cyc, miss, rv_cnt, busy_cnt;
    jobs[0]  = '{0, M_DONE,   50, 32'h3F00_0000, 32'h3F80_0000, 1'b0, 0,  32'h3F80_0000, 1'b1, 2'b00};
    jobs[1]  = '{1, M_DONE,   30, 32'h3F00_0000, 32'h0000_0000, 1'b0, 3,  32'h0000_0000, 1'b0, 2'b00};
    jobs[2]  = '{1, M_DONE,   30, 32'h8000_0000, 32'h0000_0000, 1'b0, 0,  32'h0000_0000, 1'b1, 2'b00};
    jobs[3]  = '{0, M_ERR,    20, 32'h3F00_0000, 32'h3F80_0000, 1'b0, 0,  32'h0000_0000, 1'b0, 2'b01};
    jobs[4]  = '{0, M_SILENT,  0, 32'h3F00_0000, 32'h3F80_0000, 1'b0, 0,  32'h0000_0000, 1'b0, 2'b10};
    jobs[5]  = '{2, M_DONE,   40, 32'h3F80_0000, 32'h3F80_0000, 1'b1, 10, 32'h3F80_0000, 1'b1, 2'b00};
    jobs[6]  = '{2, M_DONE,    5, 32'hBF80_0000, 32'hC000_0000, 1'b0, 0,  32'hC000_0000, 1'b0, 2'b00};
    jobs[7]  = '{2, M_DONE,    5, 32'hC000_0000, 32'hBF80_0000, 1'b0, 0,  32'hBF80_0000, 1'b1, 2'b00};
    jobs[8]  = '{1, M_DONE,    5, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 0,  32'h7FC0_0000, 1'b0, 2'b00};
    jobs[9]  = '{0, M_DONE,    5, 32'h3F80_0000, 32'h3F7F_FFFF, 1'b0, 0,  32'h3F7F_FFFF, 1'b0, 2'b00};
    jobs[10] = '{1, M_DONE,    5, 32'h8000_0001, 32'h0000_0000, 1'b0, 2,  32'h0000_0000, 1'b1, 2'b00};
    jobs[11] = '{0, M_DONE,    1, 32'h7F80_0000, 32'h7F80_0000, 1'b0, 0,  32'h7F80_0000, 1'b1, 2'b00};

    repeat (3) @(negedge clk);
    check("rst in_ready", 64'(in_ready), 1);
    check("rst busy", 64'(busy), 0);
    check("rst resp_valid", 64'(resp_valid), 0);
    check("rst ip_start", 64'(ip_start), 0);
    check("rst resp_score", 64'(resp_score), 0);
    check("rst resp_match", 64'(resp_match), 0);
    check("rst resp_status", 64'(resp_status), 0);
    check("rst vectors", 64'((ip_vct1 != '0) || (ip_vct2 != '0)), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int j = 0; j < 5; j++) run_job(j);

    // late done after the timeout: must not disturb LOAD
    late_req = 1'b1;
    repeat (3) @(negedge clk);
    check("late busy", 64'(busy), 0);
    check("late resp_valid", 64'(resp_valid), 0);
    check("late in_ready", 64'(in_ready), 1);
    late_req = 1'b1;

    for (int j = 5; j < NJOBS; j++) run_job(j);

    // reset mid-LOAD at word 100
    mdl_mode = M_DONE; mdl_lat = 50; mdl_res = 32'h3F80_0000;
    load_words(0, 32'h3F00_0000, 1'b0, 100, last_cyc, miss);
    rst = 1'b1;
    #1;
    check("rstload vct1_e0", 64'(ip_vct1[DL-1:0]), 0);
    check("rstload in_ready", 64'(in_ready), 1);
    check("rstload busy", 64'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset mid-WAIT
    load_words(0, 32'h3F00_0000, 1'b0, 2*EN, last_cyc, miss);
    repeat (10) @(negedge clk);
    check("wait busy", 64'(busy), 1);
    rst = 1'b1;
    #1;
    check("rstwait busy", 64'(busy), 0);
    check("rstwait resp_valid", 64'(resp_valid), 0);
    check("rstwait ip_start", 64'(ip_start), 0);
    check("rstwait in_ready", 64'(in_ready), 1);
    check("rstwait vct2_e5", 64'(ip_vct2[5*DL +: DL]), 0);
    check("rstwait status", 64'(resp_status), 0);
    @(negedge clk);
    rst = 1'b0;
    rv_cnt = 0;
    busy_cnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (resp_valid) rv_cnt++;
      if (busy) busy_cnt++;
    end
    check("rstwait no_resp", 64'(rv_cnt), 0);
    check("rstwait no_busy", 64'(busy_cnt), 0);

    run_job(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
